// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and bit-time helper for the UART transmit path.
package uart_pkg;

   localparam int BAUD       = 115200;
   localparam int FRAME_BITS = 10;

   typedef enum logic {
      IDLE = 1'b0,
      GAP  = 1'b1
   } state_t;

   function automatic int bit_cycles(input int freq);
      return freq / BAUD + 1;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with separate occupancy counter and a sticky overflow flag.
module byte_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       push_i,
   input  logic [7:0]                 data_i,
   input  logic                       pop_i,
   output logic [7:0]                 head_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [LW-1:0] r_count;
   logic          r_overflow;
   logic          w_push_ok;
   logic          w_pop_ok;

   // Full is judged on the registered count, so a pop cannot make room for a same-cycle push.
   assign full_o     = (r_count == LW'(DEPTH));
   assign empty_o    = (r_count == '0);
   assign level_o    = r_count;
   assign overflow_o = r_overflow;
   assign head_o     = r_mem[r_rd_ptr];
   assign w_push_ok  = push_i & ~full_o;
   assign w_pop_ok   = pop_i & ~empty_o;

   always_ff @(posedge clk_i) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= data_i;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push_ok && !w_pop_ok)      r_count <= r_count + LW'(1);
         else if (!w_push_ok && w_pop_ok) r_count <= r_count - LW'(1);
         if (push_i && full_o) r_overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffers core bytes and strobes them to the UART transmitter one frame time apart.
// Optional UART_TX_FIFO_CRLF_EN inserts a 0x0D frame ahead of every 0x0A.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FREQ  = 27000000,
   parameter int DEPTH = 16
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic                       push_i,
   input  logic [7:0]                 data_i,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o,
   output logic                       overflow_o,
   output logic                       tx_write_o,
   output logic [7:0]                 tx_data_o,
   output state_t                     dbg_state_o
);

   localparam logic [23:0] GAP_LOAD = 24'(FRAME_BITS * bit_cycles(FREQ) - 1);

   state_t      r_state;
   state_t      w_next_state;
   logic [23:0] r_gap;
   logic        r_tx_write;
   logic [7:0]  r_tx_data;
   logic [7:0]  w_head;
   logic        w_fifo_empty;
   logic        w_fire;
   logic        w_pop;
   logic [7:0]  w_tx_byte;

   byte_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .push_i     (push_i),
      .data_i     (data_i),
      .pop_i      (w_pop),
      .head_o     (w_head),
      .full_o     (full_o),
      .empty_o    (w_fifo_empty),
      .level_o    (level_o),
      .overflow_o (overflow_o)
   );

   assign empty_o     = w_fifo_empty;
   assign tx_write_o  = r_tx_write;
   assign tx_data_o   = r_tx_data;
   assign dbg_state_o = r_state;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) r_state <= IDLE;
      else         r_state <= w_next_state;
   end

   // Leaving GAP as the count reaches 0 lets IDLE strobe exactly one frame after the previous strobe.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: if (w_fire) w_next_state = GAP;
         GAP:  if (r_gap <= 24'd1) w_next_state = IDLE;
      endcase
   end

`ifdef UART_TX_FIFO_CRLF_EN
   logic r_cr_sent;

   always_comb begin
      w_fire    = (r_state == IDLE) && !w_fifo_empty;
      w_pop     = w_fire;
      w_tx_byte = w_head;
      if (w_fire && (w_head == 8'h0A) && !r_cr_sent) begin
         w_pop     = 1'b0;
         w_tx_byte = 8'h0D;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)     r_cr_sent <= 1'b0;
      else if (w_fire) r_cr_sent <= !w_pop;
   end
`else
   always_comb begin
      w_fire    = (r_state == IDLE) && !w_fifo_empty;
      w_pop     = w_fire;
      w_tx_byte = w_head;
   end
`endif

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_gap      <= '0;
         r_tx_write <= 1'b0;
         r_tx_data  <= '0;
      end else begin
         r_tx_write <= w_fire;
         if (w_fire) begin
            r_tx_data <= w_tx_byte;
            r_gap     <= GAP_LOAD;
         end else if ((r_state == GAP) && (r_gap != '0)) begin
            r_gap <= r_gap - 24'd1;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus random bursts against a frame-pacing model.
module tb_uart_tx_fifo;

   localparam int FREQ  = 1152000;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * (FREQ / 115200 + 1);
`ifdef UART_TX_FIFO_CRLF_EN
   localparam bit CRLF = 1'b1;
`else
   localparam bit CRLF = 1'b0;
`endif

   logic             clk;
   logic             rstn_i;
   logic             push_i;
   logic [7:0]       data_i;
   logic             full_o;
   logic             empty_o;
   logic [2:0]       level_o;
   logic             overflow_o;
   logic             tx_write_o;
   logic [7:0]       tx_data_o;
   uart_pkg::state_t dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Model: expected strobe bytes, the edge their source byte was pushed, and whether the strobe pops.
   logic [7:0] exp_q[$];
   int         avail_q[$];
   bit         pop_q[$];
   int         model_level = 0;
   bit         model_ovf   = 0;
   int         last_strobe = -100000;

   uart_tx_fifo #(.FREQ(FREQ), .DEPTH(DEPTH)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn_i),
      .push_i      (push_i),
      .data_i      (data_i),
      .full_o      (full_o),
      .empty_o     (empty_o),
      .level_o     (level_o),
      .overflow_o  (overflow_o),
      .tx_write_o  (tx_write_o),
      .tx_data_o   (tx_data_o),
      .dbg_state_o (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp_v, cyc);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      avail_q.delete();
      pop_q.delete();
      model_level = 0;
      model_ovf   = 0;
      last_strobe = -100000;
   endtask

   task automatic model_push(input logic [7:0] b, input int edge_k);
      if (model_level < DEPTH) begin
         model_level++;
         if (CRLF && (b == 8'h0A)) begin
            exp_q.push_back(8'h0D);
            avail_q.push_back(edge_k);
            pop_q.push_back(1'b0);
         end
         exp_q.push_back(b);
         avail_q.push_back(edge_k);
         pop_q.push_back(1'b1);
      end else begin
         model_ovf = 1'b1;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      push_i = 1'b1;
      data_i = b;
      @(posedge clk);
      #1;
      push_i = 1'b0;
      model_push(b, cyc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_tx_write"}, tx_write_o, 1'b0);
      check({tag, "_tx_data"},  tx_data_o,  8'h00);
      check({tag, "_full"},     full_o,     1'b0);
      check({tag, "_empty"},    empty_o,    1'b1);
      check({tag, "_level"},    level_o,    3'd0);
      check({tag, "_overflow"}, overflow_o, 1'b0);
   endtask

   // Called at posedge+1; asserts reset mid-cycle and checks outputs before any clock edge.
   task automatic apply_reset(input string tag);
      #2;
      rstn_i = 1'b0;
      #1;
      check_reset_values(tag);
      model_clear();
      idle(2);
      rstn_i = 1'b1;
   endtask

   // A strobe is due one frame after the previous one, but never before the edge after its push.
   always @(negedge clk) begin
      if (rstn_i) begin
         bit exp_w;
         int due;
         exp_w = 1'b0;
         if (exp_q.size() > 0) begin
            due = last_strobe + FRAME;
            if (avail_q[0] + 1 > due) due = avail_q[0] + 1;
            exp_w = (cyc == due);
         end
         check("tx_write", tx_write_o, exp_w);
         if (exp_w) begin
            check("tx_data", tx_data_o, exp_q[0]);
            if (pop_q[0]) model_level--;
            last_strobe = cyc;
            void'(exp_q.pop_front());
            void'(avail_q.pop_front());
            void'(pop_q.pop_front());
         end
         check("level",    level_o,    model_level);
         check("empty",    empty_o,    model_level == 0);
         check("full",     full_o,     model_level == DEPTH);
         check("overflow", overflow_o, model_ovf);
      end
   end

   initial begin
      int k;
      int burst;
      logic [7:0] b;
      rstn_i = 1'b0;
      push_i = 1'b0;
      data_i = 8'h00;
      #2;
      check_reset_values("por");
      idle(3);
      rstn_i = 1'b1;
      idle(2);

      push_byte(8'h41);
      idle(150);

      push_byte(8'h01);
      push_byte(8'h02);
      push_byte(8'h03);
      idle(400);

      push_byte(8'h0A);
      idle(300);

      // Fill while the lead byte's frame is in flight; the fifth push finds the FIFO full.
      push_byte(8'h0F);
      push_byte(8'h10);
      push_byte(8'h11);
      push_byte(8'h12);
      push_byte(8'h13);
      check("full_after_4", full_o, 1'b1);
      push_byte(8'h14);
      check("ovf_after_5", overflow_o, 1'b1);
      idle(700);

      apply_reset("rst_a");
      idle(2);

      // Push while full on the very edge a pop happens.
      push_byte(8'h20);
      k = cyc;
      push_byte(8'h21);
      push_byte(8'h22);
      push_byte(8'h23);
      push_byte(8'h24);
      while (cyc < k + FRAME) idle(1);
      push_byte(8'h55);
      check("same_cycle_level", level_o, DEPTH - 1);
      check("same_cycle_ovf", overflow_o, 1'b1);
      idle(700);

      apply_reset("rst_b");
      idle(2);

      push_byte(8'h30);
      push_byte(8'h31);
      push_byte(8'h32);
      idle(20);
      apply_reset("rst_midgap");
      idle(300);
      check("post_reset_empty", empty_o, 1'b1);

      for (int it = 0; it < 150; it++) begin
         idle($urandom_range(0, 60));
         burst = $urandom_range(1, 4);
         for (int j = 0; j < burst; j++) begin
            b = ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom);
            push_byte(b);
         end
      end
      idle(1000);
      check("drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
